// File: rtl/qed_pkg.sv
// Shared constants for the QED duplication path: RV32I opcodes, field positions
// and the state encoding used by qed_dup_buffer.
package qed_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [31:0] QED_NOP    = 32'h0000_0013;

    localparam int OPC_LSB  = 0;
    localparam int OPC_W    = 7;
    localparam int RD_LSB   = 7;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int REG_W    = 5;
    localparam int IMM_LSB  = 20;
    localparam int IMM_W    = 12;
    localparam int SIMM_LO  = 7;
    localparam int SIMM_HI  = 25;

    typedef enum logic {ORIG, DUP} qed_state_e;

    function automatic logic is_supported(input logic [6:0] opc);
        return (opc == OPC_OP_IMM) || (opc == OPC_OP) ||
               (opc == OPC_LOAD)   || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/qed_dup_xform.sv
// Combinational EDDI-V transform: remaps registers into the upper bank and
// shifts load/store immediates into the shadow memory region.
module qed_dup_xform
    import qed_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int MEM_OFFSET = 512
) (
    input  logic [31:0] instr,
    output logic [31:0] dup_instr
);

    localparam logic [REG_W-1:0] HALF = REG_W'(NUM_REGS / 2);
    localparam logic [IMM_W-1:0] OFF  = IMM_W'(MEM_OFFSET);

    // x0 stays x0; registers already in the upper bank pass through untouched
    function automatic logic [REG_W-1:0] remap(input logic [REG_W-1:0] r);
        if (r == '0 || r >= HALF)
            return r;
        return r + HALF;
    endfunction

    logic [IMM_W-1:0] st_imm;

    always_comb begin
        dup_instr = instr;
        st_imm    = {instr[31:SIMM_HI], instr[SIMM_LO +: REG_W]} + OFF;
        case (instr[OPC_LSB +: OPC_W])
            OPC_OP_IMM: begin
                dup_instr[RD_LSB  +: REG_W] = remap(instr[RD_LSB  +: REG_W]);
                dup_instr[RS1_LSB +: REG_W] = remap(instr[RS1_LSB +: REG_W]);
            end
            OPC_OP: begin
                dup_instr[RD_LSB  +: REG_W] = remap(instr[RD_LSB  +: REG_W]);
                dup_instr[RS1_LSB +: REG_W] = remap(instr[RS1_LSB +: REG_W]);
                dup_instr[RS2_LSB +: REG_W] = remap(instr[RS2_LSB +: REG_W]);
            end
            OPC_LOAD: begin
                dup_instr[RD_LSB  +: REG_W] = remap(instr[RD_LSB  +: REG_W]);
                dup_instr[RS1_LSB +: REG_W] = remap(instr[RS1_LSB +: REG_W]);
                dup_instr[IMM_LSB +: IMM_W] = instr[IMM_LSB +: IMM_W] + OFF;
            end
            OPC_STORE: begin
                dup_instr[RS1_LSB +: REG_W] = remap(instr[RS1_LSB +: REG_W]);
                dup_instr[RS2_LSB +: REG_W] = remap(instr[RS2_LSB +: REG_W]);
                dup_instr[31:SIMM_HI]       = st_imm[IMM_W-1:REG_W];
                dup_instr[SIMM_LO +: REG_W] = st_imm[REG_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/qed_dup_buffer.sv
// QED stage between IFU and decode: passes originals through while recording
// them, then stalls fetch and replays the recorded block as duplicates.
module qed_dup_buffer
    import qed_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int NUM_REGS   = 32,
    parameter int MEM_OFFSET = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       exec_dup,
    input  logic                       stall_IF,
    input  logic                       ifu_qed_valid,
    input  logic [31:0]                ifu_qed_instruction,
    output logic [31:0]                qed_ifu_instruction,
    output logic                       vld_out,
    output logic                       qed_ifu_stall,
    output logic                       dup_active,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, cnt_after;
    qed_state_e       state;
    logic             adv, accept, push;
    logic [31:0]      head_dup;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign adv           = ena & ~stall_IF;
    assign qed_ifu_stall = (state == DUP);
    assign dup_active    = (state == DUP);
    assign fifo_count    = count;
    assign accept        = ifu_qed_valid & ~qed_ifu_stall;
    assign push          = accept & is_supported(ifu_qed_instruction[OPC_LSB +: OPC_W]);
    assign cnt_after     = count + CNT_W'(push);

    qed_dup_xform #(
        .NUM_REGS   (NUM_REGS),
        .MEM_OFFSET (MEM_OFFSET)
    ) u_xform (
        .instr     (mem[rd_ptr]),
        .dup_instr (head_dup)
    );

    always_ff @(posedge clk) begin
        if (!rst && adv && state == ORIG && push)
            mem[wr_ptr] <= ifu_qed_instruction;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ORIG;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            qed_ifu_instruction <= '0;
            vld_out             <= 1'b0;
        end else if (adv) begin
            if (state == ORIG) begin
                vld_out <= accept;
                if (accept)
                    qed_ifu_instruction <= push ? ifu_qed_instruction : QED_NOP;
                if (push)
                    wr_ptr <= next_ptr(wr_ptr);
                count <= cnt_after;
                // a same-cycle push is counted before deciding to replay
                if ((exec_dup && cnt_after != '0) || cnt_after == CNT_W'(DEPTH))
                    state <= DUP;
            end else begin
                qed_ifu_instruction <= head_dup;
                vld_out             <= 1'b1;
                rd_ptr              <= next_ptr(rd_ptr);
                count               <= count - 1'b1;
                if (count == CNT_W'(1))
                    state <= ORIG;
            end
        end
    end

endmodule

// File: tb/tb_qed_dup_buffer.sv
// Directed bench for qed_dup_buffer: passthrough, replay transform, full-forced
// replay, downstream stall, unsupported opcodes and reset during replay.
module tb_qed_dup_buffer;

    logic        clk = 1'b0;
    logic        rst, ena, exec_dup, stall_IF, ifu_qed_valid;
    logic [31:0] ifu_qed_instruction;
    logic [31:0] qed_ifu_instruction;
    logic        vld_out, qed_ifu_stall, dup_active;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    qed_dup_buffer #(.DEPTH(8), .NUM_REGS(32), .MEM_OFFSET(512)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena                 (ena),
        .exec_dup            (exec_dup),
        .stall_IF            (stall_IF),
        .ifu_qed_valid       (ifu_qed_valid),
        .ifu_qed_instruction (ifu_qed_instruction),
        .qed_ifu_instruction (qed_ifu_instruction),
        .vld_out             (vld_out),
        .qed_ifu_stall       (qed_ifu_stall),
        .dup_active          (dup_active),
        .fifo_count          (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        return {12'(imm), 5'd0, 3'd0, 5'(rd), 7'h13};
    endfunction

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; exec_dup = 1'b0; stall_IF = 1'b0;
        ifu_qed_valid = 1'b0; ifu_qed_instruction = 32'h0;
        step(); step();
        rst = 1'b0;
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", vld_out); end
        checks++; if (qed_ifu_instruction !== 32'h0) begin errors++; $display("FAIL reset_out got %h exp 00000000", qed_ifu_instruction); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fifo_count); end
        checks++; if (dup_active !== 1'b0 || qed_ifu_stall !== 1'b0) begin errors++; $display("FAIL reset_state got dup=%0b stall=%0b exp 0 0", dup_active, qed_ifu_stall); end
    endtask

    task automatic test_passthrough();
        ifu_qed_valid = 1'b1; ifu_qed_instruction = 32'h0070_0093; exec_dup = 1'b1;
        step();
        ifu_qed_valid = 1'b0; exec_dup = 1'b0;
        checks++; if (qed_ifu_instruction !== 32'h0070_0093 || vld_out !== 1'b1) begin errors++; $display("FAIL pass_orig got %h/%0b exp 00700093/1", qed_ifu_instruction, vld_out); end
        checks++; if (qed_ifu_stall !== 1'b1 || dup_active !== 1'b1) begin errors++; $display("FAIL pass_enter_dup got stall=%0b dup=%0b exp 1 1", qed_ifu_stall, dup_active); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL pass_cnt1 got %0d exp 1", fifo_count); end
        step();
        checks++; if (qed_ifu_instruction !== 32'h0070_0893 || vld_out !== 1'b1) begin errors++; $display("FAIL pass_dup got %h/%0b exp 00700893/1", qed_ifu_instruction, vld_out); end
        checks++; if (fifo_count !== 4'd0 || dup_active !== 1'b0 || qed_ifu_stall !== 1'b0) begin errors++; $display("FAIL pass_back_orig got cnt=%0d dup=%0b stall=%0b exp 0 0 0", fifo_count, dup_active, qed_ifu_stall); end
        step();
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL pass_idle_vld got %0b exp 0", vld_out); end
    endtask

    task automatic test_load_store();
        ifu_qed_valid = 1'b1; ifu_qed_instruction = 32'h00F0_2383;
        step();
        ifu_qed_instruction = 32'h08F2_A023;
        step();
        checks++; if (qed_ifu_instruction !== 32'h08F2_A023 || fifo_count !== 4'd2) begin errors++; $display("FAIL ls_orig got %h cnt=%0d exp 08f2a023 cnt=2", qed_ifu_instruction, fifo_count); end
        ifu_qed_valid = 1'b0; exec_dup = 1'b1;
        step();
        exec_dup = 1'b0;
        checks++; if (dup_active !== 1'b1 || vld_out !== 1'b0) begin errors++; $display("FAIL ls_enter got dup=%0b vld=%0b exp 1 0", dup_active, vld_out); end
        step();
        checks++; if (qed_ifu_instruction !== 32'h20F0_2B83) begin errors++; $display("FAIL ls_load_dup got %h exp 20f02b83", qed_ifu_instruction); end
        step();
        checks++; if (qed_ifu_instruction !== 32'h29FA_A023) begin errors++; $display("FAIL ls_store_dup got %h exp 29faa023", qed_ifu_instruction); end
        checks++; if (dup_active !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL ls_exit got dup=%0b cnt=%0d exp 0 0", dup_active, fifo_count); end
    endtask

    task automatic test_full();
        ifu_qed_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifu_qed_instruction = addi(i + 1, i);
            step();
        end
        // input stays valid during replay and must be ignored
        ifu_qed_instruction = addi(9, 99);
        checks++; if (fifo_count !== 4'd8 || dup_active !== 1'b1 || qed_ifu_stall !== 1'b1) begin errors++; $display("FAIL full_forced got cnt=%0d dup=%0b stall=%0b exp 8 1 1", fifo_count, dup_active, qed_ifu_stall); end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) ifu_qed_valid = 1'b0;
            step();
            checks++; if (qed_ifu_instruction !== addi(i + 17, i) || vld_out !== 1'b1) begin errors++; $display("FAIL full_dup%0d got %h exp %h", i, qed_ifu_instruction, addi(i + 17, i)); end
            if (i < 7) begin
                checks++; if (qed_ifu_stall !== 1'b1) begin errors++; $display("FAIL full_stall%0d got %0b exp 1", i, qed_ifu_stall); end
            end
        end
        checks++; if (fifo_count !== 4'd0 || dup_active !== 1'b0) begin errors++; $display("FAIL full_exit got cnt=%0d dup=%0b exp 0 0", fifo_count, dup_active); end
    endtask

    task automatic test_stall_if();
        ifu_qed_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifu_qed_instruction = addi(i + 2, i + 40);
            exec_dup = (i == 2);
            step();
        end
        ifu_qed_valid = 1'b0; exec_dup = 1'b0;
        step();
        checks++; if (qed_ifu_instruction !== addi(18, 40) || fifo_count !== 4'd2) begin errors++; $display("FAIL stl_first got %h cnt=%0d exp %h cnt=2", qed_ifu_instruction, fifo_count, addi(18, 40)); end
        stall_IF = 1'b1;
        step(); step();
        checks++; if (qed_ifu_instruction !== addi(18, 40) || fifo_count !== 4'd2 || vld_out !== 1'b1) begin errors++; $display("FAIL stl_hold got %h cnt=%0d vld=%0b exp %h 2 1", qed_ifu_instruction, fifo_count, vld_out, addi(18, 40)); end
        stall_IF = 1'b0; ena = 1'b0;
        step();
        checks++; if (qed_ifu_instruction !== addi(18, 40) || fifo_count !== 4'd2) begin errors++; $display("FAIL ena_hold got %h cnt=%0d exp %h 2", qed_ifu_instruction, fifo_count, addi(18, 40)); end
        ena = 1'b1;
        step();
        checks++; if (qed_ifu_instruction !== addi(19, 41) || fifo_count !== 4'd1) begin errors++; $display("FAIL stl_resume got %h cnt=%0d exp %h 1", qed_ifu_instruction, fifo_count, addi(19, 41)); end
        step();
        checks++; if (qed_ifu_instruction !== addi(20, 42) || dup_active !== 1'b0) begin errors++; $display("FAIL stl_last got %h dup=%0b exp %h 0", qed_ifu_instruction, dup_active, addi(20, 42)); end
    endtask

    task automatic test_unsupported();
        exec_dup = 1'b1; ifu_qed_valid = 1'b0;
        step();
        exec_dup = 1'b0;
        checks++; if (dup_active !== 1'b0) begin errors++; $display("FAIL empty_dup got %0b exp 0", dup_active); end
        ifu_qed_valid = 1'b1; ifu_qed_instruction = addi(3, 5);
        step();
        ifu_qed_instruction = 32'h0000_006F;
        step();
        ifu_qed_valid = 1'b0;
        checks++; if (qed_ifu_instruction !== 32'h0000_0013 || vld_out !== 1'b1) begin errors++; $display("FAIL unsup_nop got %h/%0b exp 00000013/1", qed_ifu_instruction, vld_out); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL unsup_cnt got %0d exp 1", fifo_count); end
    endtask

    task automatic test_reset_mid_dup();
        ifu_qed_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ifu_qed_instruction = addi(i + 4, i);
            exec_dup = (i == 1);
            step();
        end
        ifu_qed_valid = 1'b0; exec_dup = 1'b0;
        checks++; if (fifo_count !== 4'd3 || dup_active !== 1'b1) begin errors++; $display("FAIL rmd_pending got cnt=%0d dup=%0b exp 3 1", fifo_count, dup_active); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (vld_out !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL rmd_flush got vld=%0b cnt=%0d exp 0 0", vld_out, fifo_count); end
        checks++; if (dup_active !== 1'b0 || qed_ifu_stall !== 1'b0) begin errors++; $display("FAIL rmd_state got dup=%0b stall=%0b exp 0 0", dup_active, qed_ifu_stall); end
        step();
        checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL rmd_no_dup got %0b exp 0", vld_out); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_store();
        test_full();
        test_stall_if();
        test_unsupported();
        test_reset_mid_dup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qed_dup_buffer.md
Name: qed_dup_buffer

Overview:
- Parametrised successor to the single-instruction QED transform between the IFU and decode.
- Passes original instructions through and records each one in a DEPTH-entry buffer.
- On exec_dup, or when the buffer is full, stalls fetch and replays the buffered instructions in order as duplicates (EDDI-V): registers remapped to the upper bank, load/store immediates offset into the shadow memory region.

Parameters:
- DEPTH, 8: buffer entries, ≥2, any integer; pointers wrap at DEPTH.
- NUM_REGS, 32: architectural registers. Original bank is x0..x(NUM_REGS/2-1). Duplicate register = original + NUM_REGS/2; x0 maps to x0.
- MEM_OFFSET, 512: added to the 12-bit immediate of duplicated LOAD/STORE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  block enable; low freezes all state
- exec_dup  in  1  request to enter duplicate phase
- stall_IF  in  1  downstream stall; output registers hold
- ifu_qed_valid  in  1  input instruction valid
- ifu_qed_instruction  in  32  RV32I instruction from IFU
- qed_ifu_instruction  out  32  instruction to decode (registered)
- vld_out  out  1  qed_ifu_instruction valid
- qed_ifu_stall  out  1  backpressure to IFU; high in DUP
- dup_active  out  1  state == DUP
- fifo_count  out  $clog2(DEPTH+1)  buffered entries

Behaviour:
- Reset (sync): state ORIG, buffer empty, qed_ifu_instruction=0, vld_out=0, fifo_count=0. Reset mid-DUP flushes the buffer; no further duplicates are emitted.
- Advance condition: adv = ena & ~stall_IF. When adv=0, all registers, outputs and state hold; vld_out holds its value.

ORIG state:
- Accept when adv & ifu_qed_valid & ~qed_ifu_stall.
- Supported opcodes: OP-IMM 0010011, OP 0110011, LOAD 0000011, STORE 0100011.
- Accepted supported instruction: emitted unchanged next cycle with vld_out=1, and pushed to the buffer.
- Accepted unsupported opcode: emitted as NOP 0x00000013, not pushed.
- No accept with adv=1: vld_out=0 next cycle.
- Go to DUP next cycle if (exec_dup & count_after_push>0) or count_after_push==DEPTH.
- exec_dup together with a valid input: the input is pushed first and is included in the replay.
- exec_dup with an empty buffer is ignored.

DUP state:
- qed_ifu_stall=1 combinationally; input is ignored.
- Each adv cycle pops the head and emits the transformed instruction next cycle with vld_out=1.
- The pop that empties the buffer returns to ORIG the following cycle.
- exec_dup is ignored in DUP.

Transform:
- rd (OP-IMM, OP, LOAD), rs1 (all four) and rs2 (OP, STORE) get +NUM_REGS/2 unless the field is 0. Fields already in the upper bank are passed unmodified; correctness is the program generator's responsibility.
- LOAD imm[31:20] += MEM_OFFSET; STORE {imm[31:25], imm[11:7]} += MEM_OFFSET. The sum is modulo 2^12, with no overflow flag.
- Latency: input or buffer head to output is 1 cycle. Max throughput is 1 instruction per cycle in both states.
- Full: a push that reaches DEPTH forces DUP; no push is ever attempted while full, because qed_ifu_stall is high.

Decomposition:
- qed_pkg: opcode constants, QED_NOP, state enum {ORIG, DUP}, instruction field bit positions.
- Sub-module qed_dup_xform: combinational 32-bit transform, parametrised by NUM_REGS and MEM_OFFSET.
- Buffer storage and control stay in qed_dup_buffer.

Test Plan:
- Passthrough and single replay: push 0x00700093 (addi x1,x0,7), then exec_dup=1 → out 0x00700093, then qed_ifu_stall=1 and out 0x00700893 (addi x17,x0,7), vld_out=1, then back to ORIG with fifo_count=0.
- Load replay: push 0x00F02383 (lw x7,15(x0)), exec_dup → duplicate 0x20F02B83 (lw x23,527(x0)). Store 0x08F2A023 (sw x15,128(x5)) → 0x29FAA023 (sw x31,640(x21)).
- Full: 8 valid addi, no exec_dup → after the 8th push, DUP forced; 8 duplicates emitted in FIFO order; qed_ifu_stall high throughout.
- stall_IF: assert stall_IF for 2 cycles mid-DUP → output and fifo_count hold; replay resumes with no duplicate lost or repeated.
- Unsupported opcode: input 0x0000006F (jal) → output 0x00000013, fifo_count unchanged.
- Reset mid-DUP: rst with 3 entries pending → next cycle vld_out=0, fifo_count=0, dup_active=0, qed_ifu_stall=0.
